// File: rtl/filt_addr_pkg.sv
// Shared encodings and default widths for the filter-tile address generator.
package filt_addr_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 32;

  localparam logic LAYOUT_KCRS = 1'b0;
  localparam logic LAYOUT_KRSC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP1,
    ST_SETUP2,
    ST_RUN,
    ST_FIN
  } state_e;

endpackage

// File: rtl/filt_loop_counter.sv
// One loop level: bounded up-counter plus a running address that either steps
// by its stride or, on wrap, reloads from the next outer level's next address.
module filt_loop_counter
  import filt_addr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_max,
  input  logic [ADDR_W-1:0] load_stride,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              en,
  input  logic [ADDR_W-1:0] carry_addr,
  output logic              wrap,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] next_addr
);

  logic [DATA_W-1:0] cnt_q;
  logic [DATA_W-1:0] max_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] addr_q;

  assign wrap      = (cnt_q == max_q);
  assign next_addr = wrap ? carry_addr : addr_q + stride_q;
  assign addr      = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      max_q    <= '0;
      stride_q <= '0;
      addr_q   <= '0;
    end else if (load) begin
      cnt_q    <= '0;
      max_q    <= load_max;
      stride_q <= load_stride;
      addr_q   <= load_addr;
    end else if (en) begin
      cnt_q  <= wrap ? '0 : cnt_q + DATA_W'(1);
      addr_q <= next_addr;
    end
  end

endmodule

// File: rtl/filt_tile_addr_gen.sv
// Streams the absolute weight addresses of one (k, c) filter tile over all R x S
// taps, in KCRS or KRSC memory order, one address per cycle under valid/ready.
module filt_tile_addr_gen
  import filt_addr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              layout,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] K,
  input  logic [DATA_W-1:0] C,
  input  logic [DATA_W-1:0] R,
  input  logic [DATA_W-1:0] S,
  input  logic [DATA_W-1:0] Tk,
  input  logic [DATA_W-1:0] Tc,
  input  logic [DATA_W-1:0] ko,
  input  logic [DATA_W-1:0] co,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_e state_q, state_d;

  logic              layout_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] k_q, c_q, r_q, s_q, tk_q, tc_q, ko_q, co_q;
  logic [ADDR_W-1:0] rs_q;
  logic [DATA_W-1:0] tk_eff_q, tc_eff_q;

  logic [ADDR_W-1:0] str_s, str_r, str_c, str_k, start_addr;
  logic [DATA_W-1:0] bnd0, bnd1, bnd2, bnd3;
  logic [ADDR_W-1:0] stp0, stp1, stp2, stp3;
  logic              empty_tile, load, fire, last_all;
  logic              en0, en1, en2, en3;
  logic              wrap0, wrap1, wrap2, wrap3;
  logic [ADDR_W-1:0] addr0, addr1, addr2, addr3;
  logic [ADDR_W-1:0] next0, next1, next2, next3;
  logic              unused_addrs;

  function automatic logic [DATA_W-1:0] clip_extent(input logic [DATA_W-1:0] dim,
                                                    input logic [DATA_W-1:0] origin,
                                                    input logic [DATA_W-1:0] tile);
    logic [DATA_W-1:0] room;
    room = dim - origin;
    if (origin >= dim) return '0;
    return (tile < room) ? tile : room;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of all others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: each always_comb assigns defaults first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_SETUP1;
      ST_SETUP1: state_d = ST_SETUP2;
      ST_SETUP2: state_d = empty_tile ? ST_FIN : ST_RUN;
      ST_RUN:    if (fire && last_all) state_d = ST_FIN;
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: configuration and setup registers are cleared on reset as well, so an
  // aborted tile leaves no stale geometry behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layout_q <= LAYOUT_KCRS;
      base_q   <= '0;
      k_q      <= '0;
      c_q      <= '0;
      r_q      <= '0;
      s_q      <= '0;
      tk_q     <= '0;
      tc_q     <= '0;
      ko_q     <= '0;
      co_q     <= '0;
      rs_q     <= '0;
      tk_eff_q <= '0;
      tc_eff_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      layout_q <= layout;
      base_q   <= base_addr;
      k_q      <= K;
      c_q      <= C;
      r_q      <= R;
      s_q      <= S;
      tk_q     <= Tk;
      tc_q     <= Tc;
      ko_q     <= ko;
      co_q     <= co;
    end else if (state_q == ST_SETUP1) begin
      rs_q     <= ADDR_W'(r_q) * ADDR_W'(s_q);
      tk_eff_q <= clip_extent(k_q, ko_q, tk_q);
      tc_eff_q <= clip_extent(c_q, co_q, tc_q);
    end
  end

  // Strides and per-level bounds; only consumed while loading in SETUP2.
  always_comb begin
    str_s = ADDR_W'(1);
    str_r = ADDR_W'(s_q);
    str_c = rs_q;
    str_k = ADDR_W'(c_q) * rs_q;
    bnd0 = s_q;      stp0 = str_s;
    bnd1 = r_q;      stp1 = str_r;
    bnd2 = tc_eff_q; stp2 = str_c;
    bnd3 = tk_eff_q; stp3 = str_k;
    if (layout_q == LAYOUT_KRSC) begin
      str_c = ADDR_W'(1);
      str_s = ADDR_W'(c_q);
      str_r = ADDR_W'(s_q) * ADDR_W'(c_q);
      str_k = rs_q * ADDR_W'(c_q);
      bnd0 = tc_eff_q; stp0 = str_c;
      bnd1 = s_q;      stp1 = str_s;
      bnd2 = r_q;      stp2 = str_r;
    end
    start_addr = base_q + ADDR_W'(ko_q) * str_k + ADDR_W'(co_q) * str_c;
  end

  assign empty_tile = (tk_eff_q == '0) || (tc_eff_q == '0) || (r_q == '0) || (s_q == '0);
  assign load       = (state_q == ST_SETUP2);
  assign fire       = (state_q == ST_RUN) && out_ready;
  assign last_all   = wrap0 && wrap1 && wrap2 && wrap3;

  // Innermost level steps on every handshake; each outer level steps when all
  // inner levels wrap together.
  assign en0 = fire;
  assign en1 = en0 && wrap0;
  assign en2 = en1 && wrap1;
  assign en3 = en2 && wrap2;

  filt_loop_counter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lvl0 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_max(bnd0 - DATA_W'(1)),
    .load_stride(stp0), .load_addr(start_addr), .en(en0), .carry_addr(next1),
    .wrap(wrap0), .addr(addr0), .next_addr(next0)
  );

  filt_loop_counter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lvl1 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_max(bnd1 - DATA_W'(1)),
    .load_stride(stp1), .load_addr(start_addr), .en(en1), .carry_addr(next2),
    .wrap(wrap1), .addr(addr1), .next_addr(next1)
  );

  filt_loop_counter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lvl2 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_max(bnd2 - DATA_W'(1)),
    .load_stride(stp2), .load_addr(start_addr), .en(en2), .carry_addr(next3),
    .wrap(wrap2), .addr(addr2), .next_addr(next2)
  );

  // The outermost level has nothing above it; its wrap coincides with the end.
  filt_loop_counter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lvl3 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_max(bnd3 - DATA_W'(1)),
    .load_stride(stp3), .load_addr(start_addr), .en(en3), .carry_addr(addr3),
    .wrap(wrap3), .addr(addr3), .next_addr(next3)
  );

  assign unused_addrs = ^{next0, addr1, addr2};

  assign out_addr  = addr0;
  assign out_valid = (state_q == ST_RUN);
  assign out_last  = out_valid && last_all;
  assign busy      = (state_q == ST_SETUP1) || (state_q == ST_SETUP2) || (state_q == ST_RUN);
  assign done      = (state_q == ST_FIN);

endmodule

// File: tb/tb_filt_tile_addr_gen.sv
// Self-checking bench: directed tiles plus randomized tiles compared against a
// tensor-index reference model of the address stream.
module tb_filt_tile_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        layout;
  logic [31:0] base_addr;
  logic [15:0] K, C, R, S, Tk, Tc, ko, co;
  logic [31:0] out_addr;
  logic        out_valid, out_ready, out_last, busy, done;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  filt_tile_addr_gen #(.DATA_W(16), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layout(layout), .base_addr(base_addr),
    .K(K), .C(C), .R(R), .S(S), .Tk(Tk), .Tc(Tc), .ko(ko), .co(co),
    .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int clip(input int dim, input int origin, input int tile);
    if (origin >= dim) return 0;
    return (tile < dim - origin) ? tile : dim - origin;
  endfunction

  // Reference: walk the tile in memory order and map each tensor index to a word.
  task automatic build_model(input bit lay, input logic [31:0] base, input int k_d, input int c_d,
                             input int r_d, input int s_d, input int tk, input int tc,
                             input int k0, input int c0);
    int tke, tce, idx;
    exp_q.delete();
    tke = clip(k_d, k0, tk);
    tce = clip(c_d, c0, tc);
    for (int k = k0; k < k0 + tke; k++) begin
      if (!lay) begin
        for (int c = c0; c < c0 + tce; c++)
          for (int r = 0; r < r_d; r++)
            for (int s = 0; s < s_d; s++) begin
              idx = ((k * c_d + c) * r_d + r) * s_d + s;
              exp_q.push_back(base + 32'(idx));
            end
      end else begin
        for (int r = 0; r < r_d; r++)
          for (int s = 0; s < s_d; s++)
            for (int c = c0; c < c0 + tce; c++) begin
              idx = ((k * r_d + r) * s_d + s) * c_d + c;
              exp_q.push_back(base + 32'(idx));
            end
      end
    end
  endtask

  task automatic scramble_cfg();
    layout = 1'($urandom); base_addr = $urandom;
    K = 16'($urandom); C = 16'($urandom); R = 16'($urandom); S = 16'($urandom);
    Tk = 16'($urandom); Tc = 16'($urandom); ko = 16'($urandom); co = 16'($urandom);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1,1,0,1 repeating, 2: random ready.
  task automatic run_tile(input bit lay, input logic [31:0] base, input int k_d, input int c_d,
                          input int r_d, input int s_d, input int tk, input int tc,
                          input int k0, input int c0, input int mode);
    int n, idx, cyc;
    bit rdy, prev_stall;
    logic [31:0] prev_addr;
    logic prev_last;
    bit ready_pat[7];
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    build_model(lay, base, k_d, c_d, r_d, s_d, tk, tc, k0, c0);
    n = exp_q.size();

    @(negedge clk);
    layout = lay; base_addr = base;
    K = 16'(k_d); C = 16'(c_d); R = 16'(r_d); S = 16'(s_d);
    Tk = 16'(tk); Tc = 16'(tc); ko = 16'(k0); co = 16'(c0);
    start = 1'b1; out_ready = 1'b0;

    @(negedge clk);
    start = 1'b0;
    scramble_cfg();
    check("setup1_busy", busy, 1);
    check("setup1_valid", out_valid, 0);
    check("setup1_done", done, 0);
    @(negedge clk);
    check("setup2_busy", busy, 1);
    check("setup2_valid", out_valid, 0);
    @(negedge clk);

    idx = 0; cyc = 0; prev_stall = 1'b0; prev_addr = '0; prev_last = 1'b0;
    while (idx < n && cyc < 4000) begin
      check("valid_held", out_valid, 1);
      check("run_busy", busy, 1);
      if (prev_stall) begin
        check("stall_addr", out_addr, prev_addr);
        check("stall_last", out_last, prev_last);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ready_pat[cyc % 7];
        default: rdy = ($urandom_range(0, 99) < 70);
      endcase
      out_ready = rdy;
      if (rdy) begin
        check("addr", out_addr, exp_q[idx]);
        check("last", out_last, idx == n - 1);
        idx++;
      end
      prev_stall = !rdy; prev_addr = out_addr; prev_last = out_last;
      cyc++;
      @(negedge clk);
    end
    check("handshakes", idx, n);

    check("fin_valid", out_valid, 0);
    check("fin_done", done, 1);
    check("fin_busy", busy, 0);
    // A start raised together with done must be ignored.
    out_ready = 1'($urandom);
    scramble_cfg();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    @(negedge clk);
    check("fin_start_ignored_busy", busy, 0);
    check("fin_start_ignored_valid", out_valid, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    layout = 1'b0; base_addr = '0;
    K = '0; C = '0; R = '0; S = '0; Tk = '0; Tc = '0; ko = '0; co = '0;
    #3;
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_last", out_last, 0);
    check("reset_addr", out_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_tile(1'b0, 32'h0,   2, 3, 2, 2, 1, 1, 1, 1, 0);   // 16..19
    run_tile(1'b1, 32'h0,   2, 3, 2, 2, 1, 1, 1, 1, 0);   // 13,16,19,22
    run_tile(1'b0, 32'h100, 4, 1, 1, 2, 2, 1, 3, 0, 0);   // 0x106,0x107
    run_tile(1'b0, 32'h40,  2, 3, 2, 2, 1, 0, 1, 1, 0);   // Tc=0: no addresses
    run_tile(1'b0, 32'h0,   2, 3, 2, 2, 1, 1, 1, 1, 1);   // stalled 16..19

    // Asynchronous reset in the middle of a tile.
    @(negedge clk);
    layout = 1'b0; base_addr = '0;
    K = 16'd2; C = 16'd3; R = 16'd2; S = 16'd2; Tk = 16'd1; Tc = 16'd1; ko = 16'd1; co = 16'd1;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    check("abort_first", out_addr, 32'd16);
    @(negedge clk);
    check("abort_second", out_addr, 32'd17);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    check("abort_no_done", done, 0);
    rst_n = 1'b1;
    out_ready = 1'b0;
    run_tile(1'b0, 32'h0, 2, 3, 2, 2, 1, 1, 1, 1, 0);

    for (int i = 0; i < 40; i++) begin
      int rk, rc, rr, rs, rtk, rtc, rko, rco;
      rk  = $urandom_range(1, 6);
      rc  = $urandom_range(1, 5);
      rr  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
      rs  = $urandom_range(1, 3);
      rtk = $urandom_range(0, 4);
      rtc = $urandom_range(0, 4);
      rko = $urandom_range(0, 7);
      rco = $urandom_range(0, 6);
      run_tile(1'($urandom), $urandom, rk, rc, rr, rs, rtk, rtc, rko, rco,
               $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/filt_tile_addr_gen.md
Name: filt_tile_addr_gen

Overview:
- Parametrised successor filter-weight address generator for tiled convolution.
- Walks one (ko..ko+Tk, co..co+Tc) filter tile over all R×S taps and streams absolute word addresses to the weight-fetch DMA over a valid/ready interface.
- Compared with the first generation it adds:
  - one address per cycle, with no idle wrap cycles;
  - back-pressure;
  - start/busy/done control;
  - base address;
  - selectable KCRS/KRSC layout;
  - clipping of partial edge tiles against K;
  - a multiplier-free run loop.

Parameters:
- DATA_W, 16, width of every dimension, tile and offset input and of the loop counters.
- ADDR_W, 32, width of base_addr and out_addr.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request. Sampled only in IDLE.
- layout  in  1  0 = KCRS, 1 = KRSC. Latched at start.
- base_addr  in  ADDR_W  weight tensor base. Latched at start.
- K, C, R, S  in  DATA_W each  full tensor dimensions. Latched at start.
- Tk, Tc  in  DATA_W each  tile extents. Latched at start.
- ko, co  in  DATA_W each  tile origin. Latched at start.
- out_addr  out  ADDR_W  current address.
- out_valid  out  1  out_addr valid.
- out_ready  in  1  consumer accepts the address.
- out_last  out  1  marks the final address of the tile.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset is asynchronous on rst_n low:
  - state = IDLE;
  - all outputs 0;
  - counters and latched config cleared.
  - Reset mid-tile aborts immediately: no done pulse, no further addresses.
- Five states: IDLE, SETUP1, SETUP2, RUN, FIN.
- IDLE:
  - start = 1 at edge t latches all cfg inputs and goes to SETUP1.
  - start in any other state is ignored.
- Effective k extent: Tk_eff = min(Tk, K − ko), or 0 if ko ≥ K. Tc_eff uses C and co in the same way.
- SETUP1 computes RS = R·S (ADDR_W-wide) and the Tk_eff/Tc_eff clip.
- SETUP2 computes the strides:
  - KCRS: strS = 1, strR = S, strC = RS, strK = C·RS.
  - KRSC: strC = 1, strS = C, strR = S·C, strK = RS·C.
  - It also computes the start address base_addr + ko·strK + co·strC.
- Exit from SETUP2:
  - If any of Tk_eff, Tc_eff, R or S is 0 → FIN. done pulses at edge t+3 with no out_valid.
  - Otherwise → RUN. out_valid = 1 from edge t+3.
- Loop order (innermost first), which matches memory-sequential order:
  - KCRS: s, r, c, k.
  - KRSC: c, s, r, k.
- Address = base_addr + k·strK + c·strC + r·strR + s·strS, modulo 2^ADDR_W.
  - Maintained incrementally: one running register per loop level, holding that level's start address.
  - Only adders are used in RUN.
- Handshake:
  - An address is consumed when out_valid && out_ready.
  - While out_ready = 0, out_addr and out_last hold stable and counters do not advance.
  - out_valid never drops once raised until the final handshake.
  - On handshake the next address appears on the following edge. Sustained throughput is 1 address/cycle.
- out_last = 1 exactly with the final address, where every counter is at its maximum.
- After the final handshake, next edge:
  - out_valid = 0, busy = 0, done = 1 for one cycle;
  - state returns to IDLE through FIN.
- Total handshakes = Tk_eff·Tc_eff·R·S.
- busy:
  - = 1 in SETUP1, SETUP2 and RUN;
  - = 0 in IDLE and FIN.
- The cfg inputs may change freely after the start cycle; only latched values are used.
- start in the same cycle as done (FIN) is ignored; the next start is accepted one cycle later in IDLE.

Decomposition:
- Package filt_addr_pkg:
  - layout encodings (LAYOUT_KCRS = 0, LAYOUT_KRSC = 1);
  - state encoding;
  - default widths.
- One sub-module, filt_loop_counter. It is a bounded up-counter with enable, a wrap output and a running-address accumulator with stride input. It is instantiated once per loop level (4×) and chained by wrap.

Test Plan:
- C=3, R=2, S=2, K=2, ko=1, co=1, Tk=1, Tc=1, base=0, layout=KCRS, out_ready=1 → addresses 16, 17, 18, 19 on consecutive cycles from t+3; out_last with 19; done at the next edge.
- Same cfg, layout=KRSC → addresses 13, 16, 19, 22; out_last with 22.
- K=4, ko=3, Tk=2, C=1, co=0, Tc=1, R=1, S=2, base=0x100, KCRS → only k=3: addresses 0x106, 0x107; exactly 2 handshakes.
- Tc=0 (others nonzero), start at t → no out_valid; busy = 1 for t+1 to t+2; done pulse at t+3.
- First test with out_ready toggled 1, 0, 0, 1, 1, 0, 1 → out_addr stable while stalled; sequence 16 to 19 unchanged, no drops or duplicates.
- rst_n low asynchronously mid-RUN after the second address → out_valid, busy and done fall to 0 immediately. A new start after release produces the full sequence from its first address.
